branch_operand_scoreboard: RTL and testbench
============================================

Name: branch_operand_scoreboard

Overview:
- Per-register scoreboard that schedules branch-operand readiness in the ID stage of the 5-stage MIPS pipeline.
- Tracks every in-flight register writer by stage (E/M/W) and by remaining cycles-to-result (Tnew).
- Produces the ID stall request and the forwarding selects for the rs/rt operands feeding the branch comparator.
- Counts stall cycles for performance monitoring.

Parameters:
- NREG, 32, number of architectural GPRs tracked; entry 0 hard-wired empty.
- TW, 2, width of the Tnew/Tuse fields.
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  5  rs field of the ID instruction.
- id_rt  in  5  rt field of the ID instruction.
- id_use_rs  in  1  instruction reads rs.
- id_use_rt  in  1  instruction reads rt (beq/bne, etc.).
- id_tuse_rs  in  TW  cycles until rs is needed; 0 for branch compare.
- id_tuse_rt  in  TW  cycles until rt is needed.
- id_wr  in  1  instruction writes a GPR.
- id_dst  in  5  destination GPR.
- id_tnew  in  TW  cycles after entering E until result is forwardable (jal 0, ALU 1, load 2).
- flush  in  1  exception/eret flush; kills the instructions in E and M.
- stall  out  1  hold PC/ID; insert bubble into E.
- fwd_rs_sel  out  2  0=regfile, 1=from E, 2=from M, 3=from W.
- fwd_rt_sel  out  2  same encoding as fwd_rs_sel.
- stall_cnt  out  CNT_W  saturating count of cycles with stall=1.

Behaviour:
- State per register r (1..31):
  - stage[r] ∈ {NONE, E, M, W}.
  - tnew[r], TW bits.
- Reset (reset=0, asynchronous): all stage=NONE, tnew=0, stall_cnt=0.
  - Outputs then: stall=0, fwd sels=0.
- Stall (combinational, from current state):
  - stall = id_valid & ((id_use_rs & hit(id_rs, id_tuse_rs)) | (id_use_rt & hit(id_rt, id_tuse_rt))).
  - hit(s, tu) = s≠0 & stage[s]≠NONE & tnew[s]>tu.
  - Forced to 0 while flush=1.
- Forward select (combinational): fwd_x_sel = 0 if reg=0 or stage=NONE, else 1/2/3 for E/M/W.
  - Valid only when stall=0; while stall=1 the value is don't-care for consumers but must still follow the same encoding.
- issue = id_valid & ~stall & ~flush & id_wr & (id_dst≠0).
- Per-edge update, in order:
  - Aging: every entry ages each cycle, because E/M/W always advance.
    - E→M, M→W, W→NONE.
    - tnew = (tnew==0) ? 0 : tnew−1.
  - Flush: entries whose pre-edge stage is E or M become NONE, tnew=0.
    - W entries age normally and retire.
  - Issue: entry[id_dst] ← {stage=E, tnew=id_tnew}.
    - Overrides any aging result for the same register: youngest writer wins.
    - An older in-flight writer to the same register is dropped, which is safe because it retires earlier.
- stall_cnt increments when stall=1 and holds at all-ones (no wrap).
- Sources are checked against the pre-edge state, so there is no same-cycle bypass from the issuing instruction to itself.
- Register 0 is never written, never hit, and always selects 0.
- Latency: stall/fwd are zero-cycle combinational; scoreboard updates take effect the next cycle.

Test Plan:
- Load-use stall:
  - Stimulus: issue lw $1 (tnew=2); next cycle beq $1,$2 (tuse 0,0).
  - Response: stall=1 for 2 cycles (entry E/2, then M/1). Third cycle: stall=0, fwd_rs_sel=3, fwd_rt_sel=0. stall_cnt=2.
- ALU forward:
  - Stimulus: issue addu $3 (tnew=1); next cycle bgtz $3.
  - Response: stall=1 for 1 cycle, then stall=0, fwd_rs_sel=2.
- $0 and non-user sources:
  - Stimulus: issue addu $0 (tnew=1), then beq $0,$0.
  - Response: stall=0, sels 0.
  - Also: bgez $5 with id_use_rt=0 and rt=$3 pending → no stall.
- Flush:
  - Stimulus: writers to $4 in W, $5 in M, $6 in E; assert flush one cycle.
  - Response: next cycle $5/$6 NONE; $4 retired; beq $5,$6 → stall=0, sels 0.
  - A concurrent issue during the flush cycle is ignored.
- Same-register writers:
  - Stimulus: lw $7 (tnew=2), then addu $7 (tnew=1) issued the following cycle; then bne $7,$0.
  - Response: entry E/1, stall 1 cycle, then fwd_rs_sel=2.
- Reset mid-operation:
  - Stimulus: pull reset low between edges with stall=1.
  - Response: stall=0, sels 0, stall_cnt=0 immediately, with no clock edge required.

Source files
------------

// File: rtl/branch_operand_scoreboard_if.sv
// rtl/branch_operand_scoreboard_if.sv - ID-stage request/response bundle for the branch operand scoreboard
//
// Purpose: carries the decoded ID instruction, the flush request, and the
//          scoreboard's stall / forwarding / performance results.
// Modports:
//   master - ID stage: drives id_* and flush, reads stall, fwd_*_sel, stall_cnt
//   slave  - scoreboard: reads id_* and flush, drives stall, fwd_*_sel, stall_cnt

interface branch_operand_scoreboard_if #(
    parameter int TW    = 2,
    parameter int CNT_W = 32
);
    logic             id_valid;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic [TW-1:0]    id_tuse_rs;
    logic [TW-1:0]    id_tuse_rt;
    logic             id_wr;
    logic [4:0]       id_dst;
    logic [TW-1:0]    id_tnew;
    logic             flush;
    logic             stall;
    logic [1:0]       fwd_rs_sel;
    logic [1:0]       fwd_rt_sel;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_tuse_rs, id_tuse_rt,
        output id_wr, id_dst, id_tnew, flush,
        input  stall, fwd_rs_sel, fwd_rt_sel, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_tuse_rs, id_tuse_rt,
        input  id_wr, id_dst, id_tnew, flush,
        output stall, fwd_rs_sel, fwd_rt_sel, stall_cnt
    );
endinterface

// File: rtl/branch_operand_scoreboard.sv
// rtl/branch_operand_scoreboard.sv - per-register writer scoreboard for ID-stage branch operands
//
// Purpose: tracks each in-flight GPR writer by pipeline stage (E/M/W) and by
//          cycles remaining until its result is forwardable (tnew); produces the
//          ID stall request, rs/rt forwarding selects and a saturating stall counter.
// Ports:
//   clk   - clock, all state updates on the rising edge
//   reset - asynchronous active-low reset
//   sb    - slave side of branch_operand_scoreboard_if (ID instruction in,
//           stall / fwd_rs_sel / fwd_rt_sel / stall_cnt out)

module branch_operand_scoreboard #(
    parameter int NREG  = 32,
    parameter int TW    = 2,
    parameter int CNT_W = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    branch_operand_scoreboard_if.slave sb
);
    // Stage encoding doubles as the forwarding-select encoding.
    localparam logic [1:0] ST_NONE = 2'd0;
    localparam logic [1:0] ST_E    = 2'd1;
    localparam logic [1:0] ST_M    = 2'd2;
    localparam logic [1:0] ST_W    = 2'd3;

    logic [1:0]    stage_q [NREG];
    logic [TW-1:0] tnew_q  [NREG];
    logic [CNT_W-1:0] stall_cnt_q;

    logic rs_pend, rt_pend;
    logic rs_hit, rt_hit;
    logic stall_c;
    logic issue;

    // Sources are looked up in the pre-edge state only, so an instruction
    // never bypasses to itself.
    always_comb begin
        rs_pend = (sb.id_rs != 5'd0) && (stage_q[sb.id_rs] != ST_NONE);
        rt_pend = (sb.id_rt != 5'd0) && (stage_q[sb.id_rt] != ST_NONE);
        rs_hit  = rs_pend && (tnew_q[sb.id_rs] > sb.id_tuse_rs);
        rt_hit  = rt_pend && (tnew_q[sb.id_rt] > sb.id_tuse_rt);
        stall_c = sb.id_valid && !sb.flush &&
                  ((sb.id_use_rs && rs_hit) || (sb.id_use_rt && rt_hit));
        issue   = sb.id_valid && !stall_c && !sb.flush && sb.id_wr && (sb.id_dst != 5'd0);
    end

    assign sb.stall      = stall_c;
    assign sb.fwd_rs_sel = rs_pend ? stage_q[sb.id_rs] : ST_NONE;
    assign sb.fwd_rt_sel = rt_pend ? stage_q[sb.id_rt] : ST_NONE;
    assign sb.stall_cnt  = stall_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREG; r++) begin
                stage_q[r] <= ST_NONE;
                tnew_q[r]  <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            stage_q[0] <= ST_NONE;
            tnew_q[0]  <= '0;
            for (int r = 1; r < NREG; r++) begin
                if (issue && (sb.id_dst == 5'(r))) begin
                    // Youngest writer wins; an older writer to the same
                    // register retires earlier, so dropping it is safe.
                    stage_q[r] <= ST_E;
                    tnew_q[r]  <= sb.id_tnew;
                end else if (sb.flush && (stage_q[r] == ST_E || stage_q[r] == ST_M)) begin
                    stage_q[r] <= ST_NONE;
                    tnew_q[r]  <= '0;
                end else begin
                    // The pipeline always advances, so every entry ages.
                    stage_q[r] <= (stage_q[r] == ST_NONE || stage_q[r] == ST_W) ?
                                  ST_NONE : stage_q[r] + 2'd1;
                    tnew_q[r]  <= (tnew_q[r] == '0) ? '0 : tnew_q[r] - 1'b1;
                end
            end
            if (stall_c && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_branch_operand_scoreboard.sv
// tb/tb_branch_operand_scoreboard.sv - directed vector bench for branch_operand_scoreboard

module tb_branch_operand_scoreboard;
    localparam int TW    = 2;
    localparam int CNT_W = 32;

    logic clk;
    logic reset;

    branch_operand_scoreboard_if #(.TW(TW), .CNT_W(CNT_W)) sb ();

    branch_operand_scoreboard #(.NREG(32), .TW(TW), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          valid;
        logic [4:0]    rs;
        logic [4:0]    rt;
        logic          use_rs;
        logic          use_rt;
        logic [TW-1:0] tuse_rs;
        logic [TW-1:0] tuse_rt;
        logic          wr;
        logic [4:0]    dst;
        logic [TW-1:0] tnew;
        logic          flush;
        logic          e_stall;
        logic [1:0]    e_rs;
        logic [1:0]    e_rt;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;
    int   exp_cnt = 0;

    function automatic vec_t mk(
        input logic v, input int rs, input int rt, input logic urs, input logic urt,
        input int trs, input int trt, input logic wr, input int dst, input int tn,
        input logic fl, input logic es, input int ers, input int ert);
        vec_t x;
        x.valid = v;   x.rs = 5'(rs);   x.rt = 5'(rt);
        x.use_rs = urs; x.use_rt = urt;
        x.tuse_rs = TW'(trs); x.tuse_rt = TW'(trt);
        x.wr = wr;  x.dst = 5'(dst);  x.tnew = TW'(tn);  x.flush = fl;
        x.e_stall = es; x.e_rs = 2'(ers); x.e_rt = 2'(ert);
        return x;
    endfunction

    task automatic check(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic drive(input vec_t x);
        sb.id_valid = x.valid;  sb.id_rs = x.rs;  sb.id_rt = x.rt;
        sb.id_use_rs = x.use_rs; sb.id_use_rt = x.use_rt;
        sb.id_tuse_rs = x.tuse_rs; sb.id_tuse_rt = x.tuse_rt;
        sb.id_wr = x.wr;  sb.id_dst = x.dst;  sb.id_tnew = x.tnew;  sb.flush = x.flush;
    endtask

    initial begin
        //            v  rs rt urs urt trs trt wr dst tn fl | stall rs rt
        vecs.push_back(mk(0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0)); // reset state
        // load-use: lw $1, then beq $1,$2 held in ID
        vecs.push_back(mk(1,  0, 0, 0, 0, 0, 0, 1, 1, 2, 0,   0, 0, 0));
        vecs.push_back(mk(1,  1, 2, 1, 1, 0, 0, 0, 0, 0, 0,   1, 1, 0));
        vecs.push_back(mk(1,  1, 2, 1, 1, 0, 0, 0, 0, 0, 0,   1, 2, 0));
        vecs.push_back(mk(1,  1, 2, 1, 1, 0, 0, 0, 0, 0, 0,   0, 3, 0));
        // ALU forward: addu $3, bgtz $3
        vecs.push_back(mk(1,  0, 0, 0, 0, 0, 0, 1, 3, 1, 0,   0, 0, 0));
        vecs.push_back(mk(1,  3, 0, 1, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0));
        vecs.push_back(mk(1,  3, 0, 1, 0, 0, 0, 0, 0, 0, 0,   0, 2, 0));
        // $0 writer ignored, $0 sources never hit
        vecs.push_back(mk(1,  0, 0, 0, 0, 0, 0, 1, 0, 1, 0,   0, 0, 0));
        vecs.push_back(mk(1,  0, 0, 1, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0));
        // unused rt pending in E does not stall, select still reported
        vecs.push_back(mk(1,  0, 0, 0, 0, 0, 0, 1, 3, 1, 0,   0, 0, 0));
        vecs.push_back(mk(1,  5, 3, 1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1));
        // flush: $4 in W, $5 in M, $6 in E; concurrent issue of $8 dropped
        vecs.push_back(mk(1,  0, 0, 0, 0, 0, 0, 1, 4, 1, 0,   0, 0, 0));
        vecs.push_back(mk(1,  0, 0, 0, 0, 0, 0, 1, 5, 2, 0,   0, 0, 0));
        vecs.push_back(mk(1,  0, 0, 0, 0, 0, 0, 1, 6, 2, 0,   0, 0, 0));
        vecs.push_back(mk(1,  4, 5, 1, 1, 0, 0, 1, 8, 1, 1,   0, 3, 2));
        vecs.push_back(mk(1,  5, 6, 1, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0));
        vecs.push_back(mk(1,  4, 8, 1, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0));
        // same-register writers: lw $7 then addu $7, then bne $7,$0
        vecs.push_back(mk(1,  0, 0, 0, 0, 0, 0, 1, 7, 2, 0,   0, 0, 0));
        vecs.push_back(mk(1,  0, 0, 0, 0, 0, 0, 1, 7, 1, 0,   0, 0, 0));
        vecs.push_back(mk(1,  7, 0, 1, 1, 0, 0, 0, 0, 0, 0,   1, 1, 0));
        vecs.push_back(mk(1,  7, 0, 1, 1, 0, 0, 0, 0, 0, 0,   0, 2, 0));
        // later use (tuse=1): lw $10 then consumer of rt
        vecs.push_back(mk(1,  0, 0, 0, 0, 0, 0, 1, 10, 2, 0,  0, 0, 0));
        vecs.push_back(mk(1,  0, 10, 0, 1, 0, 1, 0, 0, 0, 0,  1, 0, 1));
        vecs.push_back(mk(1,  0, 10, 0, 1, 0, 1, 0, 0, 0, 0,  0, 0, 2));

        reset = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(negedge clk);
            check($sformatf("vec%0d stall", i), sb.stall, vecs[i].e_stall);
            check($sformatf("vec%0d fwd_rs_sel", i), sb.fwd_rs_sel, vecs[i].e_rs);
            check($sformatf("vec%0d fwd_rt_sel", i), sb.fwd_rt_sel, vecs[i].e_rt);
            check($sformatf("vec%0d stall_cnt", i), sb.stall_cnt, exp_cnt);
            if (vecs[i].e_stall) exp_cnt++;
            @(posedge clk); #1;
        end

        // Asynchronous reset between edges while a stall is pending.
        drive(mk(1, 0, 0, 0, 0, 0, 0, 1, 9, 2, 0, 0, 0, 0));
        @(posedge clk); #1;
        drive(mk(1, 9, 9, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        check("pre_reset stall", sb.stall, 1);
        check("pre_reset stall_cnt", sb.stall_cnt, exp_cnt);
        #2 reset = 1'b0;
        #1;
        check("async_reset stall", sb.stall, 0);
        check("async_reset fwd_rs_sel", sb.fwd_rs_sel, 0);
        check("async_reset fwd_rt_sel", sb.fwd_rt_sel, 0);
        check("async_reset stall_cnt", sb.stall_cnt, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_reset stall", sb.stall, 0);
        check("post_reset fwd_rs_sel", sb.fwd_rs_sel, 0);
        check("post_reset stall_cnt", sb.stall_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
